arm_imm_encoder: RTL and testbench

//  Inverse of the Val2 immediate path. Finds the ARM data-processing immediate encoding of a 32-bit value:

---
 rtl/arm_imm_encoder.sv | 131 +++++++++++++
 tb/tb_arm_imm_encoder.sv | 133 +++++++++++++
 2 files changed

// File: rtl/arm_imm_encoder.sv
// Finds the ARM data-processing immediate {rot, imm8} for a 32-bit value, testing one even rotation per clock.
// Define ARM_IMM_ENC_INVERT_EN to add a second pass that searches ~value (MVN/BIC form).
module arm_imm_encoder #(
    parameter int WIDTH    = 32,
    parameter int IMM_BITS = 8,
    parameter int ROT_BITS = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [WIDTH-1:0]             value,
    output logic                         busy,
    output logic                         done,
    output logic                         valid,
    output logic [ROT_BITS+IMM_BITS-1:0] shift_operand,
    output logic                         inverted
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [WIDTH-1:0]      value_q;
    logic [ROT_BITS-1:0]   rot;
    logic [WIDTH-1:0]      src;
    logic [WIDTH-1:0]      cand;
    logic                  hit;
    logic                  last_rot;
    logic                  final_miss;
    logic                  accept;

    // Rotate left by 2*k; the upper half of the doubled word is the rotated result.
    function automatic logic [WIDTH-1:0] rol_even(input logic [WIDTH-1:0] x,
                                                  input logic [ROT_BITS-1:0] k);
        logic [2*WIDTH-1:0] dbl;
        dbl = {x, x} << {k, 1'b0};
        return dbl[2*WIDTH-1:WIDTH];
    endfunction

`ifdef ARM_IMM_ENC_INVERT_EN
    logic pass;
    logic inverted_q;

    assign src        = pass ? ~value_q : value_q;
    assign final_miss = last_rot && pass;
    assign inverted   = inverted_q;
`else
    assign src        = value_q;
    assign final_miss = last_rot;
    assign inverted   = 1'b0;
`endif

    assign cand     = rol_even(src, rot);
    assign hit      = ~|cand[WIDTH-1:IMM_BITS];
    assign last_rot = &rot;
    assign accept   = start && (state != SEARCH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = start ? SEARCH : IDLE;
            SEARCH:  state_next = (hit || final_miss) ? DONE : SEARCH;
            DONE:    state_next = start ? SEARCH : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == SEARCH);
        done = (state == DONE);
    end

    // Operand copy is pure data: no reset needed, loaded only on an accepted request.
    always_ff @(posedge clk) begin
        if (accept) begin
            value_q <= value;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rot           <= '0;
            valid         <= 1'b0;
            shift_operand <= '0;
`ifdef ARM_IMM_ENC_INVERT_EN
            pass          <= 1'b0;
            inverted_q    <= 1'b0;
`endif
        end else if (accept) begin
            rot  <= '0;
`ifdef ARM_IMM_ENC_INVERT_EN
            pass <= 1'b0;
`endif
        end else if (state == SEARCH) begin
            if (hit) begin
                valid         <= 1'b1;
                shift_operand <= {rot, cand[IMM_BITS-1:0]};
`ifdef ARM_IMM_ENC_INVERT_EN
                inverted_q    <= pass;
`endif
            end else if (final_miss) begin
                valid         <= 1'b0;
                shift_operand <= '0;
`ifdef ARM_IMM_ENC_INVERT_EN
                inverted_q    <= 1'b0;
`endif
            end else begin
                // Counter wraps to 0 after the last rotation, which restarts the inverted pass.
                rot <= rot + 1'b1;
`ifdef ARM_IMM_ENC_INVERT_EN
                if (last_rot) begin
                    pass <= 1'b1;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_arm_imm_encoder.sv
// Directed bench for arm_imm_encoder: latency, encodings, miss, back-to-back starts and mid-search reset.
module tb_arm_imm_encoder;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] value;
    logic        busy;
    logic        done;
    logic        valid;
    logic [11:0] shift_operand;
    logic        inverted;

    int total;
    int passed;

    arm_imm_encoder dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .value         (value),
        .busy          (busy),
        .done          (done),
        .valid         (valid),
        .shift_operand (shift_operand),
        .inverted      (inverted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    endtask

    // Issue a start at the next edge, then count edges until done (bounded).
    task automatic run_case(input string tag, input logic [31:0] v, input int exp_edges,
                            input logic exp_valid, input logic [11:0] exp_so,
                            input logic exp_inv);
        int n;
        @(negedge clk);
        start = 1'b1;
        value = v;
        @(posedge clk);
        #1;
        start = 1'b0;
        value = 32'hDEAD_BEEF;
        n = 0;
        while (n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (done) break;
        end
        check({tag, "_edges"}, n, exp_edges);
        check({tag, "_valid"}, {31'd0, valid}, {31'd0, exp_valid});
        check({tag, "_so"}, {20'd0, shift_operand}, {20'd0, exp_so});
        check({tag, "_inv"}, {31'd0, inverted}, {31'd0, exp_inv});
    endtask

    initial begin
        total  = 0;
        passed = 0;
        rst    = 1'b1;
        start  = 1'b0;
        value  = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_so", {20'd0, shift_operand}, 32'd0);
        check("rst_inv", {31'd0, inverted}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_case("t1_ff", 32'h0000_00FF, 1, 1'b1, 12'h0FF, 1'b0);
        run_case("t2_ff000000", 32'hFF00_0000, 5, 1'b1, 12'h4FF, 1'b0);
        // Started while in DONE: back-to-back request.
        run_case("t3_wrap", 32'hF000_000F, 3, 1'b1, 12'h2FF, 1'b0);
        run_case("zero", 32'h0000_0000, 1, 1'b1, 12'h000, 1'b0);
        run_case("rot15", 32'h0000_03FC, 16, 1'b1, 12'hFFF, 1'b0);
`ifdef ARM_IMM_ENC_INVERT_EN
        run_case("t4_miss", 32'h0000_0102, 32, 1'b0, 12'h000, 1'b0);
        run_case("t6_inv", 32'hFFFF_FF00, 17, 1'b1, 12'h0FF, 1'b1);
`else
        run_case("t4_miss", 32'h0000_0102, 16, 1'b0, 12'h000, 1'b0);
        run_case("t6_noinv", 32'hFFFF_FF00, 16, 1'b0, 12'h000, 1'b0);
`endif
        run_case("t1_again", 32'h0000_00FF, 1, 1'b1, 12'h0FF, 1'b0);

        // Search a miss value, poke start at k=3, reset at k=6.
        @(negedge clk);
        start = 1'b1;
        value = 32'h0000_0102;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("t5_busy", {31'd0, busy}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1;
        value = 32'h0000_00FF;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("t5_ignored_done", {31'd0, done}, 32'd0);
        check("t5_ignored_busy", {31'd0, busy}, 32'd1);
        repeat (2) @(posedge clk);
        #1;
        check("t5_pre_rst_done", {31'd0, done}, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check("t5_busy", {31'd0, busy}, 32'd0);
        check("t5_done", {31'd0, done}, 32'd0);
        check("t5_valid", {31'd0, valid}, 32'd0);
        check("t5_so", {20'd0, shift_operand}, 32'd0);
        check("t5_inv", {31'd0, inverted}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("t5_idle_done", {31'd0, done}, 32'd0);
        check("t5_idle_busy", {31'd0, busy}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
